alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the core's combinational ALU. Accepts one
//  operation per valid/ready transfer, registers the result, and adds iterative
//  multi-cycle MUL/DIVU/REMU. Sits between decode/operand-fetch and writeback; stalls
//  upstream via in_ready_o while busy or while a result waits for out_ready_i.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=8, power of 2)
//  SHW     $clog2(WIDTH)  shift-amount width (derived localparam, not overridable)
// PORTS
//  clk          in   1      core clock, all state on rising edge
//  n_reset      in   1      asynchronous, active-low reset
//  flush_i      in   1      sync abort: drop in-flight op and any held result
//  in_valid_i   in   1      operands/op valid
//  in_ready_o   out  1      block can accept an op this cycle
//  op_i         in   4      operation code (table below)
//  rd_i         in   WIDTH  operand A (dividend, shifted value)
//  rs_i         in   WIDTH  operand B (divisor, shift amount in [SHW-1:0])
//  out_valid_o  out  1      result_o/flags valid
//  out_ready_i  in   1      consumer takes result
//  result_o     out  WIDTH  registered result
//  zero_o       out  1      result_o == 0
//  neg_o        out  1      result_o[WIDTH-1]
//  illegal_o    out  1      op unsupported in this build (result forced 0)
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low (n_reset).
//  Reset: state=IDLE; in_ready_o=1; out_valid_o=0; result_o=0; zero_o=0; neg_o=0;
//   illegal_o=0; counter=0. n_reset low mid-op aborts it; no residue after release.
//  Op codes: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 NOR, 8 XOR, 9 SLT(signed),
//   10 SLTU, 11 ROL, 12 ROR, 13 MUL (low WIDTH bits), 14 DIVU, 15 REMU.
//  Arithmetic: ADD/SUB wrap mod 2^WIDTH. Shifts/rotates use rs_i[SHW-1:0] only; rotate
//   by 0 returns rd_i unchanged. SLT/SLTU return 1 or 0 zero-extended.
//  Divide by zero: DIVU -> all ones; REMU -> rd_i. No exception.
//  FSM IDLE/BUSY/DONE; transfer = in_valid_i & in_ready_o.
//   IDLE: transfer of ops 0-12 -> DONE next cycle (latency 1). Ops 13-15 -> BUSY,
//    latch operands, counter=WIDTH-1.
//   BUSY: one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle; counter
//    decrements; at counter==0 write result_o -> DONE. Latency WIDTH+1 cycles from
//    transfer to out_valid_o. in_ready_o=0.
//   DONE: out_valid_o=1; result_o/flags stable until out_ready_i. in_ready_o =
//    out_ready_i (same-cycle drain+accept allowed: back-to-back single-cycle ops give
//    one result per clock). out_ready_i & no transfer -> IDLE.
//  in_valid_i without in_ready_o: ignored; op_i/operands need not be held by block.
//  flush_i (priority over all except reset): next cycle state=IDLE, out_valid_o=0,
//   counter=0; a transfer in the flush cycle is discarded. result_o keeps last value.
//  zero_o/neg_o/illegal_o update together with result_o; meaningful only with out_valid_o.
// CONFIGURATION
//  ALU_SEQ_MULDIV_EN defined: ops 13-15 as above, illegal_o always 0.
//  Not defined: no iterative datapath/counter synthesised; ops 13-15 complete in 1
//   cycle like single-cycle ops with result_o=0, zero_o=1, illegal_o=1.
// TESTING (WIDTH=32, ALU_SEQ_MULDIV_EN defined unless noted)
//  1. Reset then ADD 0xFFFFFFFF+1, out_ready_i=1 -> next cycle out_valid_o=1,
//     result_o=0, zero_o=1; SUB 0-1 -> 0xFFFFFFFF, neg_o=1.
//  2. Back-to-back ROL 0x80000001 by 1, ROR same by 0, SRA 0x80000000 by 31 ->
//     0x00000003, 0x80000001, 0xFFFFFFFF on three consecutive cycles, in_ready_o held 1.
//  3. MUL 0x00012345*0x00000100 -> in_ready_o low 32 cycles, out_valid_o at cycle 33,
//     result_o=0x01234500; DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF,
//     REMU 5/0 -> 5.
//  4. Backpressure: SLT -5<3 with out_ready_i=0 for 4 cycles -> result_o=1 held,
//     in_ready_o=0; new in_valid_i ignored until out_ready_i rises.
//  5. flush_i mid-DIVU (cycle 10) -> IDLE next cycle, no out_valid_o; n_reset pulse
//     mid-MUL -> all outputs at reset values immediately, next ADD 2+3 -> 5.
//  6. ALU_SEQ_MULDIV_EN undefined: MUL 3*4 -> 1-cycle latency, result_o=0,
//     illegal_o=1, zero_o=1; following AND 0xF0&0x3C -> 0x30, illegal_o=0.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operation/result bus between the issuing stage and alu_seq; WIDTH must match the ALU.
interface alu_seq_if #(parameter int WIDTH = 32);
    // Both channels use valid/ready: a beat moves on a rising clk edge where valid and
    // ready are both 1; a source holds nothing once ready is low (the ALU ignores it).
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [3:0]       op_i;
    logic [WIDTH-1:0] rd_i;
    logic [WIDTH-1:0] rs_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             neg_o;
    logic             illegal_o;
    logic [1:0]       dbg_state_o;

    modport master (
        output flush_i, in_valid_i, op_i, rd_i, rs_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, zero_o, neg_o, illegal_o, dbg_state_o
    );

    modport slave (
        input  flush_i, in_valid_i, op_i, rd_i, rs_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, zero_o, neg_o, illegal_o, dbg_state_o
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked registered ALU with optional iterative MUL/DIVU/REMU.
// Define ALU_SEQ_MULDIV_EN to build the multi-cycle datapath; otherwise ops 13-15 report illegal.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     n_reset,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_neg;
    logic             r_illegal;

    logic             w_in_ready;
    logic             w_xfer;
    logic             w_is_md;
    logic             w_go_busy;
    logic             w_ill;
    logic [SHW-1:0]   w_sh;
    logic [SHW-1:0]   w_sh_inv;
    logic [WIDTH-1:0] w_alu_res;

    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready_i);
    assign w_xfer     = bus.in_valid_i && w_in_ready;
    assign w_is_md    = (bus.op_i >= 4'd13);
    assign w_sh       = bus.rs_i[SHW-1:0];
    // Complementary rotate amount; wraps to 0 when w_sh is 0 so rotate-by-0 is identity.
    assign w_sh_inv   = -w_sh;

    always_comb begin
        w_alu_res = '0;
        case (bus.op_i)
            4'd0:    w_alu_res = bus.rd_i + bus.rs_i;
            4'd1:    w_alu_res = bus.rd_i - bus.rs_i;
            4'd2:    w_alu_res = bus.rd_i << w_sh;
            4'd3:    w_alu_res = bus.rd_i >> w_sh;
            4'd4:    w_alu_res = $signed(bus.rd_i) >>> w_sh;
            4'd5:    w_alu_res = bus.rd_i & bus.rs_i;
            4'd6:    w_alu_res = bus.rd_i | bus.rs_i;
            4'd7:    w_alu_res = ~(bus.rd_i | bus.rs_i);
            4'd8:    w_alu_res = bus.rd_i ^ bus.rs_i;
            4'd9:    w_alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.rd_i) < $signed(bus.rs_i)};
            4'd10:   w_alu_res = {{(WIDTH-1){1'b0}}, bus.rd_i < bus.rs_i};
            4'd11:   w_alu_res = (bus.rd_i << w_sh) | (bus.rd_i >> w_sh_inv);
            4'd12:   w_alu_res = (bus.rd_i >> w_sh) | (bus.rd_i << w_sh_inv);
            default: w_alu_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    // r_a: multiplicand/divisor, r_b: multiplier/dividend-then-quotient, r_acc: product/remainder.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic [1:0]       r_mop;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_a_nx;
    logic [WIDTH-1:0] w_b_nx;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_md_res;

    assign w_go_busy = w_is_md;
    assign w_ill     = 1'b0;

    always_comb begin
        w_trial  = {r_acc, r_b[WIDTH-1]} - {1'b0, r_a};
        w_a_nx   = r_a;
        w_b_nx   = r_b;
        w_acc_nx = r_acc;
        if (r_mop == 2'b01) begin
            w_acc_nx = r_acc + (r_b[0] ? r_a : '0);
            w_a_nx   = r_a << 1;
            w_b_nx   = r_b >> 1;
        end else if (w_trial[WIDTH]) begin
            // Trial subtraction went negative: keep the shifted remainder, quotient bit 0.
            w_acc_nx = {r_acc[WIDTH-2:0], r_b[WIDTH-1]};
            w_b_nx   = {r_b[WIDTH-2:0], 1'b0};
        end else begin
            w_acc_nx = w_trial[WIDTH-1:0];
            w_b_nx   = {r_b[WIDTH-2:0], 1'b1};
        end
        w_md_res = (r_mop == 2'b10) ? w_b_nx : w_acc_nx;
    end
`else
    assign w_go_busy = 1'b0;
    assign w_ill     = w_is_md;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_illegal   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mop       <= '0;
`endif
        end else if (bus.flush_i) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_xfer && w_go_busy) begin
`ifdef ALU_SEQ_MULDIV_EN
                        r_state     <= S_BUSY;
                        r_out_valid <= 1'b0;
                        r_a         <= bus.rs_i;
                        r_b         <= bus.rd_i;
                        r_acc       <= '0;
                        r_mop       <= bus.op_i[1:0];
                        r_cnt       <= SHW'(WIDTH - 1);
`endif
                    end else if (w_xfer) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_alu_res;
                        r_zero      <= (w_alu_res == '0);
                        r_neg       <= w_alu_res[WIDTH-1];
                        r_illegal   <= w_ill;
                    end else if ((r_state == S_DONE) && bus.out_ready_i) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_MULDIV_EN
                S_BUSY: begin
                    r_a   <= w_a_nx;
                    r_b   <= w_b_nx;
                    r_acc <= w_acc_nx;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - SHW'(1);
                    end else begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_md_res;
                        r_zero      <= (w_md_res == '0);
                        r_neg       <= w_md_res[WIDTH-1];
                        r_illegal   <= 1'b0;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = r_out_valid;
    assign bus.result_o    = r_result;
    assign bus.zero_o      = r_zero;
    assign bus.neg_o       = r_neg;
    assign bus.illegal_o   = r_illegal;
    assign bus.dbg_state_o = r_state;
endmodule
